systolic_skew_feeder: RTL and testbench

- Upstream feeder for the systolic PE grid. Accepts one N-lane activation vector per handshake and buffers it in a small FIFO.
- Drives the array's top edge with diagonal skew: lane i is delayed by i cycles, with a per-lane enable that drives the PE enable chain.
- Sequences tiles (STREAM, then DRAIN) and pulses tile_done when the last vector of a tile has fully entered the last lane.

---
 rtl/systolic_skew_feeder.sv | 89 ++++++++
 tb/tb_systolic_skew_feeder.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/systolic_skew_feeder.sv
// systolic_skew_feeder: FIFO-buffered vector feeder that drives a systolic array top edge with diagonal skew.
// Define SKEW_FEEDER_STATS_EN to enable the pop/bubble counters on vec_count_o and bubble_count_o.
module systolic_skew_feeder #(
  parameter int N     = 4,
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               in_valid_i,
  output logic               in_ready_o,
  input  logic [N*WIDTH-1:0] in_data_i,
  input  logic               in_last_i,
  output logic [N*WIDTH-1:0] out_data_o,
  output logic [N-1:0]       out_enable_o,
  output logic               tile_done_o,
  output logic               busy_o,
  output logic [15:0]        vec_count_o,
  output logic [15:0]        bubble_count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int VW = N * WIDTH;
  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;
  state_e      state_q;
  logic [VW:0] mem_q [DEPTH];
  logic [AW:0] wptr_q, rptr_q;
  logic [N-1:0] tap_en_q, tap_last_q;
  logic        rdy_q, empty, full, push, pop;
  logic [VW:0] head;
  assign empty        = wptr_q == rptr_q;
  assign full         = (wptr_q[AW-1:0] == rptr_q[AW-1:0]) && (wptr_q[AW] != rptr_q[AW]);
  assign in_ready_o   = rdy_q && !full;
  assign push         = in_valid_i && in_ready_o;
  assign head         = mem_q[rptr_q[AW-1:0]];
  assign tile_done_o  = tap_en_q[N-1] && tap_last_q[N-1];
  // The tile_done edge also pops, so the next tile's lane 0 follows right behind the drain
  assign pop          = !empty && (state_q == STREAM || (state_q == DRAIN && tile_done_o));
  assign busy_o       = state_q != IDLE || !empty;
  assign out_enable_o = tap_en_q;
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q[AW-1:0]] <= {in_last_i, in_data_i};
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      wptr_q     <= '0;
      rptr_q     <= '0;
      tap_en_q   <= '0;
      tap_last_q <= '0;
      rdy_q      <= 1'b0;
    end else begin
      rdy_q      <= 1'b1;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      tap_en_q   <= {tap_en_q[N-2:0], pop};
      tap_last_q <= {tap_last_q[N-2:0], pop && head[VW]};
      if (pop) state_q <= head[VW] ? DRAIN : STREAM;
      else if (state_q == DRAIN && tile_done_o) state_q <= IDLE;
      else if (state_q == IDLE && !empty) state_q <= STREAM;
    end
  end
  // Lane g keeps only its own element, delayed g cycles behind stage 0
  for (genvar g = 0; g < N; g++) begin : g_lane
    localparam int SW = (g + 1) * WIDTH;
    logic [SW-1:0] sr_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) sr_q <= '0;
      else sr_q <= (sr_q << WIDTH) | SW'(pop ? head[g*WIDTH +: WIDTH] : {WIDTH{1'b0}});
    end
    assign out_data_o[g*WIDTH +: WIDTH] = sr_q[SW-1 -: WIDTH];
  end
`ifdef SKEW_FEEDER_STATS_EN
  logic [15:0] vec_q, bub_q;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      vec_q <= '0;
      bub_q <= '0;
    end else begin
      if (pop) vec_q <= vec_q + 16'd1;
      if (state_q == STREAM && empty) bub_q <= bub_q + 16'd1;
    end
  end
  assign vec_count_o    = vec_q;
  assign bubble_count_o = bub_q;
`else
  assign vec_count_o    = '0;
  assign bubble_count_o = '0;
`endif
endmodule

// File: tb/tb_systolic_skew_feeder.sv
// tb_systolic_skew_feeder: directed vectors with hand-computed skew timelines (N=4, WIDTH=16, DEPTH=4).
module tb_systolic_skew_feeder;
  localparam int N = 4;
  localparam int W = 16;
  localparam int VW = N * W;
`ifdef SKEW_FEEDER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_last = 1'b0;
  logic [VW-1:0] in_data = '0;
  logic in_ready, tile_done, busy;
  logic [VW-1:0] out_data;
  logic [N-1:0] out_enable;
  logic [15:0] vec_count, bubble_count;
  int checks = 0, failures = 0;
  logic [VW-1:0] stim_d [32];
  logic stim_v [32], stim_l [32];
  logic [VW-1:0] slot_v [16];
  logic slot_en [16];
  logic [31:0] done_m, nrdy_m;
  int busy_end, exp_vec, exp_bub;
  always #5 clk = ~clk;
  systolic_skew_feeder #(.N(N), .WIDTH(W), .DEPTH(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_last_i(in_last), .out_data_o(out_data),
    .out_enable_o(out_enable), .tile_done_o(tile_done), .busy_o(busy),
    .vec_count_o(vec_count), .bubble_count_o(bubble_count)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask
  function automatic logic [VW-1:0] v4(input logic [15:0] a, b, c, d);
    return {d, c, b, a};
  endfunction
  task automatic clear_tables();
    for (int i = 0; i < 32; i++) begin
      stim_d[i] = '0;
      stim_v[i] = 1'b0;
      stim_l[i] = 1'b0;
    end
    for (int i = 0; i < 16; i++) begin
      slot_v[i]  = '0;
      slot_en[i] = 1'b0;
    end
    done_m = '0;
    nrdy_m = '0;
  endtask
  task automatic check_idle(input string tag);
    chk({tag, " data"}, out_data, 0);
    chk({tag, " en"}, out_enable, 0);
    chk({tag, " done"}, tile_done, 0);
    chk({tag, " busy"}, busy, 0);
    chk({tag, " ready"}, in_ready, 0);
    chk({tag, " vec"}, vec_count, 0);
    chk({tag, " bub"}, bubble_count, 0);
  endtask
  task automatic do_reset(input string tag);
    in_valid = 1'b0;
    in_last  = 1'b0;
    rst_n    = 1'b0;
    #1;
    check_idle({tag, " rst"});
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk);
    #1 chk({tag, " ready_after_rst"}, in_ready, 1);
  endtask
  task automatic run_test(input string name, input int ncyc);
    logic [VW-1:0] ed;
    logic [N-1:0] ee;
    for (int k = 0; k < ncyc; k++) begin
      in_valid = stim_v[k];
      in_data  = stim_d[k];
      in_last  = stim_l[k];
      @(posedge clk);
      #1;
      ed = '0;
      ee = '0;
      for (int i = 0; i < N; i++) begin
        int j;
        j = k - 2 - i;
        if (j >= 0 && j < 16 && slot_en[j]) begin
          ed[i*W +: W] = slot_v[j][i*W +: W];
          ee[i] = 1'b1;
        end
      end
      chk($sformatf("%s c%0d data", name, k), out_data, ed);
      chk($sformatf("%s c%0d en", name, k), out_enable, ee);
      chk($sformatf("%s c%0d done", name, k), tile_done, done_m[k]);
      chk($sformatf("%s c%0d busy", name, k), busy, k < busy_end);
      chk($sformatf("%s c%0d ready", name, k), in_ready, !nrdy_m[k]);
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    chk({name, " vec_count"}, vec_count, STATS ? exp_vec : 0);
    chk({name, " bubble_count"}, bubble_count, STATS ? exp_bub : 0);
  endtask
  task automatic setup_one();
    clear_tables();
    stim_v[0] = 1'b1;
    stim_d[0] = v4(1, 2, 3, 4);
    stim_l[0] = 1'b1;
    slot_v[0] = stim_d[0];
    slot_en[0] = 1'b1;
    done_m = 32'd1 << 5;
    busy_end = 6;
    exp_vec = 1;
    exp_bub = 0;
  endtask
  initial begin
    setup_one();
    do_reset("one");
    run_test("one", 8);
    // Three back-to-back vectors, including negative and extreme signed values
    clear_tables();
    stim_d[0] = v4(10, 11, 12, 13);
    stim_d[1] = v4(16'hffff, 16'hfffe, 16'hfffd, 16'hfffc);
    stim_d[2] = v4(16'h7fff, 16'h8000, 5, 6);
    for (int i = 0; i < 3; i++) begin
      stim_v[i]  = 1'b1;
      slot_v[i]  = stim_d[i];
      slot_en[i] = 1'b1;
    end
    stim_l[2] = 1'b1;
    done_m = 32'd1 << 7;
    busy_end = 8;
    exp_vec = 3;
    exp_bub = 0;
    do_reset("three");
    run_test("three", 10);
    // A, two STREAM bubbles, then B(last)
    clear_tables();
    stim_v[0] = 1'b1;
    stim_d[0] = v4(7, 8, 9, 10);
    stim_v[4] = 1'b1;
    stim_d[4] = v4(16'h8001, 20, 30, 40);
    stim_l[4] = 1'b1;
    slot_v[0] = stim_d[0];
    slot_en[0] = 1'b1;
    slot_v[3] = stim_d[4];
    slot_en[3] = 1'b1;
    done_m = 32'd1 << 8;
    busy_end = 9;
    exp_vec = 2;
    exp_bub = 2;
    do_reset("gap");
    run_test("gap", 11);
    // Backpressure: valid held through the drain, FIFO fills, P4 retried until accepted
    clear_tables();
    stim_v[0] = 1'b1;
    stim_d[0] = v4(100, 101, 102, 103);
    stim_l[0] = 1'b1;
    slot_v[0] = stim_d[0];
    slot_en[0] = 1'b1;
    for (int m = 0; m < 5; m++) begin
      slot_v[4+m] = v4(16'(m*16+1), 16'(m*16+2), 16'(m*16+3), 16'(m*16+4));
      slot_en[4+m] = 1'b1;
    end
    for (int k = 1; k < 8; k++) begin
      stim_v[k] = 1'b1;
      stim_d[k] = slot_v[3 + (k < 5 ? k : 5)];
      stim_l[k] = k >= 5;
    end
    done_m = (32'd1 << 5) | (32'd1 << 13);
    nrdy_m = (32'd1 << 4) | (32'd1 << 5);
    busy_end = 14;
    exp_vec = 6;
    exp_bub = 0;
    do_reset("bp");
    run_test("bp", 16);
    // Reset while lane 2 holds the element (cycle 4), then a fresh single-vector tile
    setup_one();
    do_reset("mid");
    run_test("mid_pre", 5);
    rst_n = 1'b0;
    #1;
    check_idle("mid_async");
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("mid_hold%0d done", k), tile_done, 0);
      chk($sformatf("mid_hold%0d en", k), out_enable, 0);
    end
    do_reset("again");
    run_test("again", 8);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
